stall_ctrl: RTL

//  Pipeline hazard controller; drives the stall vector consumed by every pipe_* stage register,
//  so it is the producer end of the stall[k+1:k] hold/bubble protocol.

---
 rtl/stall_ctrl_pkg.sv | 61 ++++++
 rtl/stall_ctrl_counter.sv | 69 ++++++
 rtl/stall_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stall_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//   - stall bus width and per-stage bit positions (PC, IF, ID, EX, MEM, WB)
//   - register bus width used for the redirect target
//   - FSM state encoding (RUN / FLUSH)
//   - packed request bundle and the stall priority encoder function
// -----------------------------------------------------------------------------
package stall_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int REG_W   = 32;

    // Stage indices into the stall bus
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // Stall patterns: every stage at or below the requester holds
    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_BY_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_BY_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_BY_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_BY_MEM  = 6'b011111;

    typedef enum logic [0:0] {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic mem;
        logic ex;
        logic id;
        logic ifs;
    } stall_req_t;

    // Priority encoder: the highest requesting stage wins and stalls all
    // upstream stages; lower requests are subsumed. WB never stalls.
    function automatic logic [STALL_W-1:0] stall_encode(input stall_req_t req);
        logic [STALL_W-1:0] v;
        v = STALL_NONE;
        if (req.mem) begin
            v = STALL_BY_MEM;
        end else if (req.ex) begin
            v = STALL_BY_EX;
        end else if (req.id) begin
            v = STALL_BY_ID;
        end else if (req.ifs) begin
            v = STALL_BY_IF;
        end else begin
            v = STALL_NONE;
        end
        v[STALL_WB] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/stall_ctrl_counter.sv
// -----------------------------------------------------------------------------
// stall_counter
//   Stall statistics: a saturating run-length watchdog and a wrapping
//   performance counter, both driven by the PC-stage stall bit.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   stalled  in   1 on every cycle the PC stage is stalled
//   timeout  out  sticky: set once WATCHDOG_LIMIT consecutive stalls seen
//   count    out  total stalled cycles, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module stall_counter #(
    parameter int WATCHDOG_LIMIT = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stalled,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int RUN_W = $clog2(WATCHDOG_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(WATCHDOG_LIMIT);

    logic [RUN_W-1:0]     r_run_len;
    logic [RUN_W-1:0]     w_run_len_next;
    logic                 r_timeout;
    logic [CNT_WIDTH-1:0] r_count;

    // Next run length: clear on any unstalled cycle, saturate at the limit
    always_comb begin
        w_run_len_next = r_run_len;
        if (!stalled) begin
            w_run_len_next = {RUN_W{1'b0}};
        end else if (r_run_len == RUN_LIMIT) begin
            w_run_len_next = r_run_len;
        end else begin
            w_run_len_next = r_run_len + RUN_W'(1);
        end
    end

    // Run-length, sticky timeout and performance counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run_len <= {RUN_W{1'b0}};
            r_timeout <= 1'b0;
            r_count   <= {CNT_WIDTH{1'b0}};
        end else begin
            r_run_len <= w_run_len_next;
            // Timeout is flagged in the same edge that the run length
            // reaches the limit, so it is visible right after that cycle.
            if (w_run_len_next == RUN_LIMIT) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
            if (stalled) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign timeout = r_timeout;
    assign count   = r_count;

endmodule

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//   Pipeline hazard controller. Merges per-stage stall requests into the
//   stall vector consumed by the pipe_* stage registers and sequences
//   branch-redirect flushes. Stall statistics live in stall_counter.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   req_if/id/ex/mem    per-stage stall requests
//   br_taken_i          EX resolved a taken branch this cycle
//   br_target_i         redirect target, valid with br_taken_i
//   stall_o             [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB (combinational)
//   flush_o             kill wrong-path work in IF/ID/EX (registered)
//   pc_redirect_o       PC loads pc_target_o this cycle (registered)
//   pc_target_o         registered branch target
//   timeout_o           sticky watchdog flag
//   stall_cycles_o      count of cycles with stall_o[0]==1
// -----------------------------------------------------------------------------
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int WATCHDOG_LIMIT = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_if,
    input  logic                 req_id,
    input  logic                 req_ex,
    input  logic                 req_mem,
    input  logic                 br_taken_i,
    input  logic [REG_W-1:0]     br_target_i,
    output logic [STALL_W-1:0]   stall_o,
    output logic                 flush_o,
    output logic                 pc_redirect_o,
    output logic [REG_W-1:0]     pc_target_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o
);

    stall_req_t         w_req;
    logic [STALL_W-1:0] w_stall;

    ctrl_state_e        r_state;
    logic               r_flush;
    logic               r_redirect;
    logic [REG_W-1:0]   r_target;

    assign w_req   = '{mem: req_mem, ex: req_ex, id: req_id, ifs: req_if};
    assign w_stall = stall_encode(w_req);

    // Redirect sequencer. A branch is only taken while EX is free to advance;
    // if EX is held the branch is re-presented later. Once in FLUSH, the
    // redirect pulse stays up until EX advances so the consumers cannot miss it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= CTRL_RUN;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
            r_target   <= {REG_W{1'b0}};
        end else begin
            case (r_state)
                CTRL_RUN: begin
                    if (br_taken_i && !w_stall[STALL_EX]) begin
                        r_state    <= CTRL_FLUSH;
                        r_flush    <= 1'b1;
                        r_redirect <= 1'b1;
                        r_target   <= br_target_i;
                    end else begin
                        r_state    <= CTRL_RUN;
                        r_flush    <= 1'b0;
                        r_redirect <= 1'b0;
                        r_target   <= r_target;
                    end
                end
                CTRL_FLUSH: begin
                    // br_taken_i here comes from the wrong path; ignore it.
                    if (!w_stall[STALL_EX]) begin
                        r_state    <= CTRL_RUN;
                        r_flush    <= 1'b0;
                        r_redirect <= 1'b0;
                    end else begin
                        r_state    <= CTRL_FLUSH;
                        r_flush    <= 1'b1;
                        r_redirect <= 1'b1;
                    end
                    r_target <= r_target;
                end
                default: begin
                    r_state    <= CTRL_RUN;
                    r_flush    <= 1'b0;
                    r_redirect <= 1'b0;
                    r_target   <= r_target;
                end
            endcase
        end
    end

    stall_counter #(
        .WATCHDOG_LIMIT (WATCHDOG_LIMIT),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_stall_counter (
        .clock   (clock),
        .reset   (reset),
        .stalled (w_stall[STALL_PC]),
        .timeout (timeout_o),
        .count   (stall_cycles_o)
    );

    assign stall_o       = w_stall;
    assign flush_o       = r_flush;
    assign pc_redirect_o = r_redirect;
    assign pc_target_o   = r_target;

endmodule
